blk_mem_addr_split: RTL and testbench

//  Backing main memory for the direct-mapped data cache, plus the address splitter that feeds it.
//  - Splits a byte-agnostic word address into tag / index / offset fields.
//  - Holds MEM_BLOCKS cache-line-wide blocks, addressed by the block number {tag,index}.
//  - Supports whole-line refill reads and whole-line write-backs, one per clock.

---
 rtl/blk_mem_addr_split.sv | 75 +++++++
 tb/tb_blk_mem_addr_split.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/blk_mem_addr_split.sv
// Line-wide backing memory for the direct-mapped data cache, with the word-address
// splitter that produces tag/index/offset and the block number used to index it.
module blk_mem_addr_split #(
    parameter int unsigned MEM_BLOCKS     = 1048576,
    parameter int unsigned NUM_BLOCK      = 1024,
    parameter int unsigned WORD_PER_BLOCK = 16,
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned ADDR_BIT       = 32,
    localparam int unsigned INDEX_BIT     = $clog2(NUM_BLOCK),
    localparam int unsigned OFFSET_BIT    = $clog2(WORD_PER_BLOCK),
    localparam int unsigned TAG_BIT       = ADDR_BIT - INDEX_BIT - OFFSET_BIT,
    localparam int unsigned LINE_W        = WORD_PER_BLOCK * WORD_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_BIT-1:0]   addr,
    output logic [TAG_BIT-1:0]    tag,
    output logic [INDEX_BIT-1:0]  index,
    output logic [OFFSET_BIT-1:0] offset,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [LINE_W-1:0]     wr_line,
    output logic [LINE_W-1:0]     rd_line,
    output logic [WORD_SIZE-1:0]  rd_word,
    output logic                  rd_valid
);

    localparam int unsigned BLK_BIT = $clog2(MEM_BLOCKS);
    localparam int unsigned NUM_W   = TAG_BIT + INDEX_BIT;

    assign tag    = addr[ADDR_BIT-1 -: TAG_BIT];
    assign index  = addr[OFFSET_BIT +: INDEX_BIT];
    assign offset = addr[OFFSET_BIT-1:0];

    // Block number wraps modulo MEM_BLOCKS: the high {tag,index} bits alias.
    logic [NUM_W-1:0]   blk_num;
    logic [BLK_BIT-1:0] blk;
    assign blk_num = {tag, index};
    assign blk     = blk_num[BLK_BIT-1:0];

    generate
        if (BLK_BIT < NUM_W) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^blk_num[NUM_W-1:BLK_BIT];
        end
    endgenerate

    // Array powers up cleared and is deliberately untouched by reset.
    logic [LINE_W-1:0] mem [MEM_BLOCKS] = '{default: '0};

    logic [WORD_PER_BLOCK-1:0][WORD_SIZE-1:0] cur_words;
    assign cur_words = mem[blk];

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[blk] <= wr_line;
        end
    end

    // Read port: old contents are returned when a write hits the same block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_line  <= '0;
            rd_word  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_line <= cur_words;
                rd_word <= cur_words[offset];
            end
        end
    end

endmodule

// File: tb/tb_blk_mem_addr_split.sv
// Randomized self-checking bench for blk_mem_addr_split against an array-based
// reference of the line memory (MEM_BLOCKS reduced to 256).
module tb_blk_mem_addr_split;

    localparam int unsigned MB = 256;

    logic         clk;
    logic         rst_n;
    logic [31:0]  addr;
    logic [17:0]  tag;
    logic [9:0]   index;
    logic [3:0]   offset;
    logic         rd_en;
    logic         wr_en;
    logic [511:0] wr_line;
    logic [511:0] rd_line;
    logic [31:0]  rd_word;
    logic         rd_valid;

    blk_mem_addr_split #(.MEM_BLOCKS(MB)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .tag(tag), .index(index),
        .offset(offset), .rd_en(rd_en), .wr_en(wr_en), .wr_line(wr_line),
        .rd_line(rd_line), .rd_word(rd_word), .rd_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    logic [511:0] model [MB];
    logic [511:0] exp_line;
    logic [31:0]  exp_word;
    logic         exp_valid;

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // One clock of stimulus; the reference model is updated at the same edge.
    task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [511:0] l);
        int unsigned b;
        logic [511:0] sh;
        rd_en = r; wr_en = w; addr = a; wr_line = l;
        @(posedge clk);
        b = (a / 16) % MB;
        if (!rst_n) begin
            exp_valid = 1'b0; exp_line = '0; exp_word = '0;
        end else begin
            exp_valid = r;
            if (r) begin
                exp_line = model[b];
                sh = exp_line >> (32 * int'(a % 16));
                exp_word = sh[31:0];
            end
            if (w) model[b] = l;
        end
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_split();
        logic [31:0] a;
        addr = 32'hABCD_1234; #1;
        n_cmp++;
        if (tag !== 18'h2AF34 || index !== 10'h123 || offset !== 4'h4) begin
            n_fail++;
            $display("FAIL split_fixed: got %h/%h/%h exp 2af34/123/4", tag, index, offset);
        end
        for (int i = 0; i < 8; i++) begin
            a = $urandom; addr = a; #1;
            n_cmp++;
            if (tag !== 18'(a >> 14) || index !== 10'((a >> 4) % 1024) || offset !== 4'(a % 16)) begin
                n_fail++;
                $display("FAIL split_rand: addr %h got %h/%h/%h", a, tag, index, offset);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 32'h0000_0300, {16{32'hDEAD_BEEF}});
            n_cmp++;
            if (rd_valid !== 1'b0 || rd_line !== '0 || rd_word !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: valid %b line %h word %h exp 0", rd_valid, rd_line, rd_word);
            end
        end
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 32'h0000_0300, '0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_line !== '0) begin
            n_fail++;
            $display("FAIL reset_noWrite: valid %b line %h exp 1 / zero", rd_valid, rd_line);
        end
        cycle(1'b0, 1'b0, 32'h0, '0);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse: got %b exp 0", rd_valid);
        end
    endtask

    task automatic test_word_select();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = 32'h1000 + 32'(k);
        cycle(1'b0, 1'b1, 32'h0000_0050, l);
        cycle(1'b1, 1'b0, 32'h0000_0057, '0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_word !== 32'h1007 || rd_line !== l) begin
            n_fail++;
            $display("FAIL word_select: valid %b word %h exp 1 / 00001007", rd_valid, rd_word);
        end
        cycle(1'b0, 1'b0, 32'h0000_005C, '0);
        n_cmp++;
        if (rd_word !== 32'h1007 || rd_line !== l) begin
            n_fail++;
            $display("FAIL read_hold: word %h exp 00001007", rd_word);
        end
    endtask

    task automatic test_rbw();
        cycle(1'b1, 1'b1, 32'h0000_0A00, {512{1'b1}});
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_line !== '0) begin
            n_fail++;
            $display("FAIL rbw_old: line %h exp zero", rd_line);
        end
        cycle(1'b1, 1'b0, 32'h0000_0A03, '0);
        n_cmp++;
        if (rd_line !== {512{1'b1}} || rd_word !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL rbw_new: line %h exp all ones", rd_line);
        end
    endtask

    task automatic test_wrap();
        logic [511:0] l;
        l = rand_line();
        cycle(1'b0, 1'b1, 32'h0000_0050, l);
        cycle(1'b1, 1'b0, 32'h0000_1052, '0);
        n_cmp++;
        if (rd_line !== l || rd_line !== exp_line || rd_word !== exp_word) begin
            n_fail++;
            $display("FAIL wrap: line %h exp %h", rd_line, l);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] la, lb;
        la = rand_line(); lb = rand_line();
        cycle(1'b0, 1'b1, 32'h0000_0210, la);
        cycle(1'b0, 1'b1, 32'h0000_0220, lb);
        cycle(1'b1, 1'b0, 32'h0000_0211, '0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_line !== la) begin
            n_fail++;
            $display("FAIL b2b_first: valid %b line %h exp %h", rd_valid, rd_line, la);
        end
        cycle(1'b1, 1'b0, 32'h0000_022F, '0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_line !== lb || rd_word !== lb[511:480]) begin
            n_fail++;
            $display("FAIL b2b_second: valid %b line %h exp %h", rd_valid, rd_line, lb);
        end
        cycle(1'b0, 1'b0, 32'h0, '0);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: valid %b exp 0", rd_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            // Keep addresses in a small block window so reads often hit written lines.
            a = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 16 * 12 - 1));
            cycle(1'($urandom), 1'($urandom), a, rand_line());
            n_cmp++;
            if (rd_valid !== exp_valid || rd_line !== exp_line || rd_word !== exp_word) begin
                n_fail++;
                $display("FAIL random[%0d]: valid %b word %h exp %b %h", i, rd_valid, rd_word, exp_valid, exp_word);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        for (int i = 0; i < int'(MB); i++) model[i] = '0;
        exp_line = '0; exp_word = '0; exp_valid = 1'b0;
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_line = '0;
        test_split();
        test_reset();
        test_word_select();
        test_rbw();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
